// File: rtl/output_result_writer.sv
// Captures a one-cycle burst of PE results and serializes the valid entries
// into a single-port output-memory write stream with backpressure.
module output_result_writer #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int MAX_N  = 64,
  parameter int N_BITS = $clog2(MAX_N),
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          stall_i,
  input  logic [ADDR_W-1:0]             base_addr_i,
  input  logic [ROWS*COLS-1:0]          in_valid_i,
  input  logic [ROWS*COLS*N_BITS-1:0]   in_row_i,
  input  logic [ROWS*COLS*N_BITS-1:0]   in_col_i,
  input  logic [ROWS*COLS*DATA_W-1:0]   in_data_i,
  output logic                          ready_o,
  output logic                          busy_o,
  output logic                          mem_we_o,
  output logic [ADDR_W-1:0]             mem_addr_o,
  output logic [DATA_W-1:0]             mem_wdata_o,
  input  logic                          mem_ready_i,
  output logic                          drop_err_o
);

  localparam int NPE   = ROWS * COLS;
  localparam int SEL_W = (NPE > 1) ? $clog2(NPE) : 1;
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(MAX_N);

  typedef enum logic {
    IDLE,
    DRAIN
  } state_e;

  state_e            state_q;
  logic [NPE-1:0]    pend_q;
  logic [DATA_W-1:0] data_q [NPE];
  logic [ADDR_W-1:0] addr_q [NPE];
  logic              drop_q;

  logic [ADDR_W-1:0] cap_addr [NPE];
  logic [SEL_W-1:0]  sel;
  logic              found;
  logic [NPE-1:0]    sel_oh;
  logic [NPE-1:0]    pend_d;
  logic              last;

  always_comb begin
    for (int i = 0; i < NPE; i++) begin
      cap_addr[i] = base_addr_i
                  + STRIDE * ADDR_W'(in_row_i[i*N_BITS +: N_BITS])
                  + ADDR_W'(in_col_i[i*N_BITS +: N_BITS]);
    end
  end

  // Lowest pending flat index is written first.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < NPE; i++) begin
      if (pend_q[i] && !found) begin
        sel   = SEL_W'(i);
        found = 1'b1;
      end
    end
  end

  assign sel_oh = NPE'(1) << sel;
  assign pend_d = pend_q & ~sel_oh;
  assign last   = (pend_d == '0);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      pend_q  <= '0;
      drop_q  <= 1'b0;
      for (int i = 0; i < NPE; i++) begin
        data_q[i] <= '0;
        addr_q[i] <= '0;
      end
    end else if (!stall_i) begin
      unique case (state_q)
        IDLE: begin
          if (|in_valid_i) begin
            pend_q  <= in_valid_i;
            state_q <= DRAIN;
            for (int i = 0; i < NPE; i++) begin
              data_q[i] <= in_data_i[i*DATA_W +: DATA_W];
              addr_q[i] <= cap_addr[i];
            end
          end
        end
        DRAIN: begin
          // A burst here, even on the final write, is discarded.
          if (|in_valid_i) begin
            drop_q <= 1'b1;
          end
          if (mem_ready_i) begin
            pend_q <= pend_d;
            if (last) begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready_o     = (state_q == IDLE);
  assign busy_o      = (state_q == DRAIN);
  assign mem_we_o    = busy_o && !stall_i;
  assign mem_addr_o  = busy_o ? addr_q[sel] : '0;
  assign mem_wdata_o = busy_o ? data_q[sel] : '0;
  assign drop_err_o  = drop_q;

endmodule
